// File: rtl/tron_sprite_pkg.sv
// Shared types, palette constants and the UP-facing base bitmap for the light-cycle sprite renderer.
// The bitmap is authored at 8x8; base_pixel() resamples it for other power-of-two sprite sizes.
package tron_sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_BLINK = 2'd1,
        ST_GONE  = 2'd2
    } crash_state_e;

    typedef logic [1:0] palette_idx_t;

    localparam logic [23:0] COL_P0    = 24'h00FFFF;
    localparam logic [23:0] COL_P1    = 24'hFF8000;
    localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
    localparam logic [23:0] COL_GREY  = 24'h404040;

    localparam int BASE_LOG2 = 3;

    // Indexed [v][u]; row 0 is the nose of the bike when facing UP.
    localparam palette_idx_t BASE_BITMAP [8][8] = '{
        '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3},
        '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0},
        '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0},
        '{2'd0, 2'd1, 2'd3, 2'd1, 2'd1, 2'd3, 2'd1, 2'd0},
        '{2'd0, 2'd1, 2'd3, 2'd1, 2'd1, 2'd3, 2'd1, 2'd0},
        '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0},
        '{2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0},
        '{2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2}
    };

    function automatic palette_idx_t base_pixel(input logic [4:0] u, input logic [4:0] v,
                                                 input int log2s);
        logic [2:0] us;
        logic [2:0] vs;
        if (log2s >= BASE_LOG2) begin
            us = 3'(u >> (log2s - BASE_LOG2));
            vs = 3'(v >> (log2s - BASE_LOG2));
        end else begin
            us = 3'(u << (BASE_LOG2 - log2s));
            vs = 3'(v << (BASE_LOG2 - log2s));
        end
        return BASE_BITMAP[vs][us];
    endfunction

    function automatic logic [23:0] palette_rgb(input palette_idx_t idx, input int player_id);
        logic [23:0] rgb;
        case (idx)
            2'd1:    rgb = (player_id == 0) ? COL_P0 : COL_P1;
            2'd2:    rgb = COL_WHITE;
            2'd3:    rgb = COL_GREY;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/sprite_coord_xform.sv
// Combinational screen-to-sprite mapping: box test on 11-bit signed offsets, de-scaling and
// rotation of the scaled offset into source bitmap coordinates (u,v).
module sprite_coord_xform
    import tron_sprite_pkg::*;
#(
    parameter int SPRITE_S   = 8,
    parameter int SCALE_LOG2 = 1
)(
    input  logic [9:0]                  draw_x,
    input  logic [9:0]                  draw_y,
    input  logic [9:0]                  bike_x,
    input  logic [9:0]                  bike_y,
    input  dir_e                        dir,
    output logic                        in_box,
    output logic [$clog2(SPRITE_S)-1:0] u,
    output logic [$clog2(SPRITE_S)-1:0] v
);
    localparam int IDX_W = $clog2(SPRITE_S);
    localparam logic signed [10:0] BOX_SPAN = 11'(SPRITE_S << SCALE_LOG2);
    localparam logic [IDX_W-1:0]   S1       = IDX_W'(SPRITE_S - 1);

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic [IDX_W-1:0]   sx_s;
    logic [IDX_W-1:0]   sy_s;

    // The extra sign bit keeps offsets past the 10-bit screen edge from wrapping into the box.
    assign dx_s = $signed({1'b0, draw_x} - {1'b0, bike_x});
    assign dy_s = $signed({1'b0, draw_y} - {1'b0, bike_y});

    assign in_box = (dx_s >= 11'sd0) && (dx_s < BOX_SPAN) &&
                    (dy_s >= 11'sd0) && (dy_s < BOX_SPAN);

    assign sx_s = dx_s[SCALE_LOG2 +: IDX_W];
    assign sy_s = dy_s[SCALE_LOG2 +: IDX_W];

    // Rotate the UP-facing bitmap into the requested heading
    always_comb begin
        u = sx_s;
        v = sy_s;
        case (dir)
            DIR_UP: begin
                u = sx_s;
                v = sy_s;
            end
            DIR_RIGHT: begin
                u = sy_s;
                v = S1 - sx_s;
            end
            DIR_DOWN: begin
                u = S1 - sx_s;
                v = S1 - sy_s;
            end
            DIR_LEFT: begin
                u = S1 - sy_s;
                v = sx_s;
            end
            default: begin
                u = sx_s;
                v = sy_s;
            end
        endcase
    end

endmodule

// File: rtl/bike_sprite_renderer.sv
// Two-stage light-cycle sprite renderer with per-frame shadowed position/heading and crash FSM.
// Define SPRITE_BLINK_EN to get the blinking BLINK state between crash and GONE.
module bike_sprite_renderer
    import tron_sprite_pkg::*;
#(
    parameter int SPRITE_S     = 8,
    parameter int SCALE_LOG2   = 1,
    parameter int PLAYER_ID    = 0,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
)(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] BikeX,
    input  logic [9:0] BikeY,
    input  logic [1:0] Dir,
    input  logic       crash,
    input  logic       respawn,
    output logic       out_valid,
    output logic       sprite_on,
    output logic [7:0] SpriteR,
    output logic [7:0] SpriteG,
    output logic [7:0] SpriteB
);
    localparam int IDX_W = $clog2(SPRITE_S);

    logic [9:0]       bike_x_r;
    logic [9:0]       bike_y_r;
    dir_e             dir_r;
    crash_state_e     state_r;
    crash_state_e     state_s;
    logic             visible_s;
    logic             in_box_s;
    logic [IDX_W-1:0] u_s;
    logic [IDX_W-1:0] v_s;
    logic             s1_valid_r;
    logic             s1_in_box_r;
    logic             s1_vis_r;
    logic [IDX_W-1:0] s1_u_r;
    logic [IDX_W-1:0] s1_v_r;
    palette_idx_t     idx_s;
    logic             on_s;
    logic [23:0]      rgb_s;

`ifdef SPRITE_BLINK_EN
    localparam int BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int PERIOD_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(BLINK_PERIOD - 1);

    logic [BLINK_W-1:0]  blink_cnt_r;
    logic [BLINK_W-1:0]  blink_cnt_s;
    logic [PERIOD_W-1:0] period_cnt_r;
    logic [PERIOD_W-1:0] period_cnt_s;
    logic                phase_r;
    logic                phase_s;
`endif

    // Shadow copies so mid-frame changes of position/heading never tear the image
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bike_x_r <= 10'd0;
            bike_y_r <= 10'd0;
            dir_r    <= DIR_UP;
        end else if (frame_start) begin
            bike_x_r <= BikeX;
            bike_y_r <= BikeY;
            dir_r    <= dir_e'(Dir);
        end
    end

    // Crash/respawn next state; only frame_start lets the FSM move
    always_comb begin
        state_s   = state_r;
        visible_s = 1'b0;
`ifdef SPRITE_BLINK_EN
        blink_cnt_s  = blink_cnt_r;
        period_cnt_s = period_cnt_r;
        phase_s      = phase_r;
`endif
        if (frame_start) begin
            case (state_r)
                ST_ALIVE: begin
                    if (crash) begin
`ifdef SPRITE_BLINK_EN
                        state_s      = ST_BLINK;
                        blink_cnt_s  = {BLINK_W{1'b0}};
                        period_cnt_s = {PERIOD_W{1'b0}};
                        phase_s      = 1'b1;
`else
                        state_s = ST_GONE;
`endif
                    end else begin
                        state_s = ST_ALIVE;
                    end
                end
`ifdef SPRITE_BLINK_EN
                ST_BLINK: begin
                    if (respawn && !crash) begin
                        state_s = ST_ALIVE;
                    end else if (blink_cnt_r == BLINK_LAST) begin
                        state_s = ST_GONE;
                    end else begin
                        blink_cnt_s = blink_cnt_r + BLINK_W'(1'b1);
                        if (period_cnt_r == PERIOD_LAST) begin
                            period_cnt_s = {PERIOD_W{1'b0}};
                            phase_s      = ~phase_r;
                        end else begin
                            period_cnt_s = period_cnt_r + PERIOD_W'(1'b1);
                            phase_s      = phase_r;
                        end
                    end
                end
`endif
                ST_GONE: begin
                    if (respawn && !crash) begin
                        state_s = ST_ALIVE;
                    end else begin
                        state_s = ST_GONE;
                    end
                end
                default: state_s = ST_ALIVE;
            endcase
        end else begin
            state_s = state_r;
        end
`ifdef SPRITE_BLINK_EN
        visible_s = (state_r == ST_ALIVE) || ((state_r == ST_BLINK) && phase_r);
`else
        visible_s = (state_r == ST_ALIVE);
`endif
    end

    // Crash FSM state and blink counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_ALIVE;
`ifdef SPRITE_BLINK_EN
            blink_cnt_r  <= {BLINK_W{1'b0}};
            period_cnt_r <= {PERIOD_W{1'b0}};
            phase_r      <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
`ifdef SPRITE_BLINK_EN
            blink_cnt_r  <= blink_cnt_s;
            period_cnt_r <= period_cnt_s;
            phase_r      <= phase_s;
`endif
        end
    end

    sprite_coord_xform #(
        .SPRITE_S   (SPRITE_S),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_xform (
        .draw_x (DrawX),
        .draw_y (DrawY),
        .bike_x (bike_x_r),
        .bike_y (bike_y_r),
        .dir    (dir_r),
        .in_box (in_box_s),
        .u      (u_s),
        .v      (v_s)
    );

    // Stage 1: register box test, source coordinates and visibility
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_r  <= 1'b0;
            s1_in_box_r <= 1'b0;
            s1_vis_r    <= 1'b0;
            s1_u_r      <= {IDX_W{1'b0}};
            s1_v_r      <= {IDX_W{1'b0}};
        end else begin
            s1_valid_r  <= pix_valid;
            s1_in_box_r <= in_box_s;
            s1_vis_r    <= visible_s;
            s1_u_r      <= u_s;
            s1_v_r      <= v_s;
        end
    end

    // Stage 2 lookup: bitmap index, opacity and palette colour
    always_comb begin
        idx_s = base_pixel(5'(s1_u_r), 5'(s1_v_r), IDX_W);
        on_s  = s1_valid_r && s1_in_box_r && s1_vis_r && (idx_s != 2'd0);
        if (on_s) begin
            rgb_s = palette_rgb(idx_s, PLAYER_ID);
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Stage 2 output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            sprite_on <= 1'b0;
            SpriteR   <= 8'd0;
            SpriteG   <= 8'd0;
            SpriteB   <= 8'd0;
        end else begin
            out_valid <= s1_valid_r;
            sprite_on <= on_s;
            SpriteR   <= rgb_s[23:16];
            SpriteG   <= rgb_s[15:8];
            SpriteB   <= rgb_s[7:0];
        end
    end

endmodule
